// File: rtl/zeroriscy_vector_pkg.sv
// zeroriscy_vector_pkg: shared vector register-file sizes and writeback request types
package zeroriscy_vector_pkg;
  localparam int unsigned VREG_NUM = 16;
  localparam int unsigned VREG_AW = 4;
  localparam int unsigned VREG_DW = 32;
  typedef struct packed {
    logic valid;
    logic [VREG_AW-1:0] addr;
    logic [VREG_DW-1:0] data;
  } vwb_req_t;
  typedef enum logic {VWB_ALU, VWB_LSU} vwb_src_e;
endpackage

// File: rtl/zeroriscy_vector_scoreboard.sv
// zeroriscy_vector_scoreboard: per-register pending bits and read-hazard stall decode
module zeroriscy_vector_scoreboard
  import zeroriscy_vector_pkg::*;
#(
  parameter int unsigned N = VREG_NUM,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_i,
  input  logic [AW-1:0] alloc_addr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          rden_a_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic          rden_b_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [N-1:0]  busy_o,
  output logic          stall_o
);
  localparam logic [N-1:0] ONE = 1;
  logic [N-1:0] busy, set_mask, clr_mask;
  always_comb begin
    set_mask = alloc_i ? ONE << alloc_addr_i : '0;
    clr_mask = we_i ? ONE << waddr_i : '0;
  end
  // set is applied after clear so back-to-back reuse of a destination stays busy
  always_ff @(posedge clk)
    busy <= rst ? '0 : (busy & ~clr_mask) | set_mask;
  assign busy_o = busy;
  assign stall_o = (rden_a_i & busy[raddr_a_i]) | (rden_b_i & busy[raddr_b_i]);
endmodule

// File: rtl/zeroriscy_vector_wb_arbiter.sv
// zeroriscy_vector_wb_arbiter: round-robin ALU/LSU writeback into one registered RF port.
// Scoreboard present only when ZERORISCY_VEC_SCOREBOARD_EN is defined.
module zeroriscy_vector_wb_arbiter
  import zeroriscy_vector_pkg::*;
#(
  parameter int unsigned NUM_VREGS = VREG_NUM,
  parameter int unsigned DATA_WIDTH = VREG_DW,
  localparam int unsigned AW = $clog2(NUM_VREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [AW-1:0]         alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [AW-1:0]         lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  we_a_o,
  output logic [AW-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  input  logic                  alloc_i,
  input  logic [AW-1:0]         alloc_addr_i,
  input  logic                  rden_a_i,
  input  logic                  rden_b_i,
  input  logic [AW-1:0]         raddr_a_i,
  input  logic [AW-1:0]         raddr_b_i,
  output logic [NUM_VREGS-1:0]  busy_o,
  output logic                  stall_o
);
  vwb_src_e last_grant;
  logic gnt_alu, gnt_lsu;
  always_comb begin
    gnt_alu = !rst && alu_valid_i && (!lsu_valid_i || last_grant == VWB_LSU);
    gnt_lsu = !rst && lsu_valid_i && (!alu_valid_i || last_grant == VWB_ALU);
  end
  assign alu_ready_o = gnt_alu;
  assign lsu_ready_o = gnt_lsu;
  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_o <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      last_grant <= VWB_LSU;
    end else begin
      we_a_o <= gnt_alu | gnt_lsu;
      if (gnt_alu | gnt_lsu) begin
        waddr_a_o <= gnt_alu ? alu_waddr_i : lsu_waddr_i;
        wdata_a_o <= gnt_alu ? alu_wdata_i : lsu_wdata_i;
        last_grant <= gnt_alu ? VWB_ALU : VWB_LSU;
      end
    end
  end
`ifdef ZERORISCY_VEC_SCOREBOARD_EN
  zeroriscy_vector_scoreboard #(.N(NUM_VREGS)) u_scoreboard (
    .clk(clk),
    .rst(rst),
    .alloc_i(alloc_i),
    .alloc_addr_i(alloc_addr_i),
    .we_i(we_a_o),
    .waddr_i(waddr_a_o),
    .rden_a_i(rden_a_i),
    .raddr_a_i(raddr_a_i),
    .rden_b_i(rden_b_i),
    .raddr_b_i(raddr_b_i),
    .busy_o(busy_o),
    .stall_o(stall_o)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{alloc_i, alloc_addr_i, rden_a_i, rden_b_i, raddr_a_i, raddr_b_i};
  assign busy_o = '0;
  assign stall_o = 1'b0;
`endif
endmodule

// File: tb/tb_zeroriscy_vector_wb_arbiter.sv
// tb_zeroriscy_vector_wb_arbiter: scoreboard-queue bench for the vector writeback arbiter
module tb_zeroriscy_vector_wb_arbiter;
  import zeroriscy_vector_pkg::*;
`ifdef ZERORISCY_VEC_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, we;
  logic [3:0] alu_waddr, lsu_waddr, waddr, alloc_addr, raddr_a, raddr_b;
  logic [31:0] alu_wdata, lsu_wdata, wdata;
  logic alloc, rden_a, rden_b, stall;
  logic [15:0] busy;
  int checks = 0, errors = 0;
  logic last_alu_m, g_alu, g_lsu;
  logic [15:0] busy_m;
  vwb_req_t cur_w;
  vwb_req_t q[$];

  always #5 clk = ~clk;

  zeroriscy_vector_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .we_a_o(we), .waddr_a_o(waddr), .wdata_a_o(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .rden_a_i(rden_a), .rden_b_i(rden_b), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .busy_o(busy), .stall_o(stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; alloc = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
  endtask

  // one clock: check combinational outputs, predict, then check registered outputs after the edge
  task automatic cycle();
    vwb_req_t e;
    logic [15:0] clr, set;
    #2;
    g_alu = !rst && alu_valid && (!lsu_valid || !last_alu_m);
    g_lsu = !rst && lsu_valid && (!alu_valid || last_alu_m);
    check("alu_ready", 32'(alu_ready), 32'(g_alu));
    check("lsu_ready", 32'(lsu_ready), 32'(g_lsu));
    check("stall", 32'(stall), SB ? 32'((rden_a & busy_m[raddr_a]) | (rden_b & busy_m[raddr_b])) : 32'd0);
    e.valid = g_alu | g_lsu;
    e.addr = g_alu ? alu_waddr : lsu_waddr;
    e.data = g_alu ? alu_wdata : lsu_wdata;
    q.push_back(e);
    clr = cur_w.valid ? 16'd1 << cur_w.addr : 16'd0;
    set = alloc ? 16'd1 << alloc_addr : 16'd0;
    busy_m = rst ? 16'd0 : (busy_m & ~clr) | set;
    if (rst) last_alu_m = 1'b0;
    else if (g_alu) last_alu_m = 1'b1;
    else if (g_lsu) last_alu_m = 1'b0;
    @(posedge clk);
    #1;
    cur_w = q.pop_front();
    check("we", 32'(we), 32'(cur_w.valid));
    if (cur_w.valid) begin
      check("waddr", 32'(waddr), 32'(cur_w.addr));
      check("wdata", wdata, cur_w.data);
    end
    check("busy", 32'(busy), SB ? 32'(busy_m) : 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    cur_w = '0; busy_m = '0; last_alu_m = 1'b0;
    alu_waddr = '0; alu_wdata = '0; lsu_waddr = '0; lsu_wdata = '0;
    alloc_addr = '0; raddr_a = '0; raddr_b = '0;
    do_reset();
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    // single ALU write
    idle(); alu_valid = 1'b1; alu_waddr = 4'd3; alu_wdata = 32'hDEADBEEF;
    cycle();
    idle(); cycle();
    // contention right after reset: ALU, LSU, ALU, LSU
    do_reset();
    alu_valid = 1'b1; alu_waddr = 4'd1; alu_wdata = 32'h1111_0000;
    lsu_valid = 1'b1; lsu_waddr = 4'd2; lsu_wdata = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("order", 32'(g_alu), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (g_alu) alu_wdata = alu_wdata + 1; else lsu_wdata = lsu_wdata + 1;
    end
    // alloc 5, read-hazard until the LSU write to 5 commits
    idle(); alloc = 1'b1; alloc_addr = 4'd5; cycle();
    idle(); rden_a = 1'b1; raddr_a = 4'd5; cycle(); cycle();
    lsu_valid = 1'b1; lsu_waddr = 4'd5; lsu_wdata = 32'h5555_AAAA; cycle();
    lsu_valid = 1'b0; cycle(); cycle();
    // alloc 7 in the cycle the write to 7 commits: set wins
    idle(); lsu_valid = 1'b1; lsu_waddr = 4'd7; lsu_wdata = 32'h7777_7777; cycle();
    idle(); alloc = 1'b1; alloc_addr = 4'd7; cycle();
    idle(); alloc = 1'b1; alloc_addr = 4'd5; cycle();
    // busy = 00A0 with a write registered, then reset
    idle(); alu_valid = 1'b1; alu_waddr = 4'd1; alu_wdata = 32'hCAFE_0001; cycle();
    rst = 1'b1; cycle();
    idle();
    alu_valid = 1'b1; alu_waddr = 4'd9; alu_wdata = 32'h9999_0000;
    lsu_valid = 1'b1; lsu_waddr = 4'd10; lsu_wdata = 32'hAAAA_0000;
    cycle();
    check("post_rst_first", 32'(g_alu), 32'd1);
    cycle();
    // randomized traffic; a waiting requester holds its address and data
    for (int i = 0; i < 60; i++) begin
      if (!(alu_valid && !g_alu)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_waddr = 4'($urandom_range(0, 15));
        alu_wdata = $urandom;
      end
      if (!(lsu_valid && !g_lsu)) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_waddr = 4'($urandom_range(0, 15));
        lsu_wdata = $urandom;
      end
      alloc = ($urandom_range(0, 2) == 0);
      alloc_addr = 4'($urandom_range(0, 15));
      rden_a = $urandom_range(0, 1) == 1; raddr_a = 4'($urandom_range(0, 15));
      rden_b = $urandom_range(0, 1) == 1; raddr_b = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 29) == 0);
      cycle();
    end
    idle(); cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zeroriscy_vector_wb_arbiter.md
# zeroriscy_vector_wb_arbiter

Writeback controller for the zeroriscy vector register file. It shares the register file's single write port between the vector ALU and the vector load unit using round-robin arbitration. Writes are registered, so the port sees one clean `we`/`waddr`/`wdata` triple per cycle. An optional scoreboard tracks in-flight destination registers and raises a read-hazard stall to the issue stage.

## Interface
Parameters:
- `NUM_VREGS`, 16: number of vector registers; address width is `$clog2(NUM_VREGS)` (4).
- `DATA_WIDTH`, 32: element width written through the port.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `alu_valid_i`  in  1: ALU writeback request.
- `alu_ready_o`  out  1: ALU request accepted this cycle.
- `alu_waddr_i`  in  4: ALU destination register.
- `alu_wdata_i`  in  32: ALU result.
- `lsu_valid_i`  in  1: load-unit writeback request.
- `lsu_ready_o`  out  1: load request accepted this cycle.
- `lsu_waddr_i`  in  4: load destination register.
- `lsu_wdata_i`  in  32: load data.
- `we_a_o`  out  1: register-file write enable (registered).
- `waddr_a_o`  out  4: register-file write address (registered).
- `wdata_a_o`  out  32: register-file write data (registered).
- `alloc_i`  in  1: issue marks a destination as pending.
- `alloc_addr_i`  in  4: register being allocated.
- `rden_a_i`, `rden_b_i`  in  1 each: issue reads port A / B.
- `raddr_a_i`, `raddr_b_i`  in  4 each: issue read addresses.
- `busy_o`  out  16: per-register pending bits.
- `stall_o`  out  1: read hazard on a pending register.

## Operation
Arbitration (combinational grant, registered write):
- Only ALU valid: grant ALU.
- Only LSU valid: grant LSU.
- Both valid: grant the requester not granted most recently.
- Neither valid: no grant; `we_a_o` is 0 next cycle.
- `last_grant` updates only on an actual grant.
- The register file never back-pressures. Therefore `*_ready_o` equals that requester's grant, and a granted request is consumed in the same cycle.
- A requester holding `valid` while not ready must keep addr/data stable. It is granted no later than the second cycle of contention, so there is no starvation.
- The winning address and data are captured into the output register. `we_a_o` equals the registered "a grant occurred" flag.

Scoreboard:
- `busy[alloc_addr_i]` is set at the edge where `alloc_i` is high.
- `busy[waddr_a_o]` is cleared at the edge where `we_a_o` is high. This is the same edge at which the register file captures the data, so a read one cycle later sees the new value.
- Simultaneous set and clear of the same register: set wins. This covers back-to-back reuse of a destination.
- Allocating an already-busy register keeps it busy; there is no counting.
- A write to a non-busy register is legal and leaves the bit at 0.
- `stall_o = (rden_a_i & busy[raddr_a_i]) | (rden_b_i & busy[raddr_b_i])`, purely combinational. There is no bypass.

## Timing
- Request-to-write latency: 1 cycle. A grant in cycle N gives `we_a_o`/`waddr_a_o`/`wdata_a_o` valid in cycle N+1.
- Throughput: 1 write per cycle. Contention adds 1 cycle of wait for the loser.
- Alloc-to-busy: 1 cycle. Write-commit-to-busy-clear: same edge as the register-file write.
- Values at reset:
  - `we_a_o`=0, `waddr_a_o`=0, `wdata_a_o`=0.
  - `busy_o`=16'h0000, `stall_o`=0.
  - `last_grant`=LSU, so the ALU wins the first contention.
- Reset asserted mid-operation discards the pending registered write (`we_a_o`=0 next cycle) and clears all busy bits.
- `*_ready_o` is forced to 0 while `rst` is high.

## Configuration
Macro `ZERORISCY_VEC_SCOREBOARD_EN`:
- Defined: scoreboard instantiated as described above.
- Undefined:
  - No busy storage.
  - `busy_o` tied to 0 and `stall_o` tied to 0.
  - `alloc_*`, `rden_*` and `raddr_*` are ignored.
  - Arbitration and write timing are unchanged.

## Structure
- Shared package `zeroriscy_vector_pkg`:
  - `VREG_NUM`=16 and `VREG_AW`=4.
  - `VREG_DW`=32.
  - Typedef `vwb_req_t` (valid, addr, data).
  - Enum `vwb_src_e` {VWB_ALU, VWB_LSU}.
- One sub-module, `zeroriscy_vector_scoreboard`: busy bit array, set/clear logic and stall decode. It is instantiated under the macro.
- Arbiter and output register stay in the top module.

## Test plan
- Reset, then ALU valid with addr 3, data 32'hDEADBEEF -> `alu_ready_o`=1 the same cycle; next cycle `we_a_o`=1, `waddr_a_o`=3, `wdata_a_o`=32'hDEADBEEF.
- ALU and LSU both valid for 4 cycles, first contention after reset -> grant order ALU, LSU, ALU, LSU; each grant writes in the following cycle.
- Alloc addr 5, then `rden_a_i`=1 with `raddr_a_i`=5 -> `stall_o`=1 until the cycle after an LSU write to 5 commits; `busy_o[5]` then reads 0.
- `alloc_i` for addr 7 in the same cycle `we_a_o` writes addr 7 -> `busy_o[7]`=1 afterwards.
- `rst` high while a write is registered and `busy_o`=16'h00A0 -> next cycle `we_a_o`=0 and `busy_o`=0; the first post-reset contention goes to the ALU.
- Build without `ZERORISCY_VEC_SCOREBOARD_EN`, repeat the alloc/stall scenario -> `stall_o` stays 0; write timing is identical.
